// File: rtl/writeback_unit_if.sv
// Result-collection and register-file write bus of the writeback unit.
// The execution lanes / register file side takes the master modport;
// the writeback unit takes the slave modport.
interface writeback_unit_if #(
    parameter int SEQ_W = 4
);
    // Per-lane result push channel (lane 0 LSU, 1 IXU1, 2 IXU2, 3 BRANCH)
    logic [3:0]            res_valid;
    logic [3:0]            res_ready;
    logic [3:0][4:0]       res_rd;
    logic [3:0][31:0]      res_data;
    logic [3:0][SEQ_W-1:0] res_seq;

    // Register file write ports
    logic [3:0]            wb_wr_en;
    logic [3:0][4:0]       wb_rd;
    logic [3:0][31:0]      wb_wr_data;

    // Status toward issue
    logic [31:0]           busy;
    logic                  err_waw;

    modport master (
        output res_valid, res_rd, res_data, res_seq,
        input  res_ready, wb_wr_en, wb_rd, wb_wr_data, busy, err_waw
    );

    modport slave (
        input  res_valid, res_rd, res_data, res_seq,
        output res_ready, wb_wr_en, wb_rd, wb_wr_data, busy, err_waw
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit for the 4-lane VLIW register file.
// Each lane queues results in a small FIFO. Every cycle the head of each
// lane is released unless another lane's head targets the same nonzero
// register and belongs to an older bundle (or the same bundle on a lower
// lane). Released heads drive the registered register-file write ports.
// A pending-write scoreboard (busy) is derived from FIFO contents plus the
// output stage.
module writeback_unit #(
    parameter int DEPTH = 2,
    parameter int SEQ_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    writeback_unit_if.slave bus
);
    localparam int LANES = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Result storage, one ring buffer per lane
    logic [4:0]       mem_rd   [LANES][DEPTH];
    logic [31:0]      mem_data [LANES][DEPTH];
    logic [SEQ_W-1:0] mem_seq  [LANES][DEPTH];

    logic [PTR_W-1:0] wr_ptr [LANES];
    logic [PTR_W-1:0] rd_ptr [LANES];
    logic [CNT_W-1:0] count  [LANES];

    logic [LANES-1:0] full;
    logic [LANES-1:0] nonempty;
    logic [LANES-1:0] ready;
    logic [LANES-1:0] push;
    logic [LANES-1:0] pop;
    logic [LANES-1:0] blocked;

    logic [4:0]       head_rd   [LANES];
    logic [31:0]      head_data [LANES];
    logic [SEQ_W-1:0] head_seq  [LANES];

    // older[i][j]: head of lane j comes from an earlier bundle than head of lane i
    logic [LANES-1:0] older [LANES];

    // entry_valid[i][k]: slot k of lane i currently holds a queued result
    logic [DEPTH-1:0] entry_valid [LANES];

    logic             waw_seen;
    logic             err_reg;
    logic [31:0]      busy_vec;

    logic             wb_en_reg   [LANES];
    logic [4:0]       wb_rd_reg   [LANES];
    logic [31:0]      wb_data_reg [LANES];

    genvar gi, gj, gk;

    // ------------------------------------------------------------------
    // Per-lane FIFO and output stage
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign full[gi]     = (count[gi] == CNT_W'(DEPTH));
            assign nonempty[gi] = (count[gi] != '0);
            // Ready depends on fullness only; a popping full FIFO still refuses.
            assign ready[gi]    = rst_n & ~full[gi];
            assign push[gi]     = bus.res_valid[gi] & ready[gi];

            assign head_rd[gi]   = mem_rd[gi][rd_ptr[gi]];
            assign head_data[gi] = mem_data[gi][rd_ptr[gi]];
            assign head_seq[gi]  = mem_seq[gi][rd_ptr[gi]];

            assign bus.res_ready[gi]  = ready[gi];
            assign bus.wb_wr_en[gi]   = wb_en_reg[gi];
            assign bus.wb_rd[gi]      = wb_rd_reg[gi];
            assign bus.wb_wr_data[gi] = wb_data_reg[gi];

            // Slot occupancy: distance from read pointer below the fill count
            for (gk = 0; gk < DEPTH; gk++) begin : g_slot
                logic [PTR_W-1:0] offset;
                assign offset = PTR_W'(gk) - rd_ptr[gi];
                assign entry_valid[gi][gk] = ({1'b0, offset} < count[gi]);
            end

            // Result storage write; contents need no reset since occupancy is tracked by count
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem_rd[gi][wr_ptr[gi]]   <= bus.res_rd[gi];
                    mem_data[gi][wr_ptr[gi]] <= bus.res_data[gi];
                    mem_seq[gi][wr_ptr[gi]]  <= bus.res_seq[gi];
                end
            end

            // Pointer/count bookkeeping and registered register-file write port
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr[gi]      <= '0;
                    rd_ptr[gi]      <= '0;
                    count[gi]       <= '0;
                    wb_en_reg[gi]   <= 1'b0;
                    wb_rd_reg[gi]   <= '0;
                    wb_data_reg[gi] <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr[gi] <= wr_ptr[gi] + PTR_W'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr[gi] <= rd_ptr[gi] + PTR_W'(1);
                    end
                    count[gi] <= count[gi] + CNT_W'(push[gi]) - CNT_W'(pop[gi]);

                    if (pop[gi]) begin
                        // rd==0 results drain through here without writing
                        wb_en_reg[gi]   <= (head_rd[gi] != 5'd0);
                        wb_rd_reg[gi]   <= head_rd[gi];
                        wb_data_reg[gi] <= head_data[gi];
                    end else begin
                        wb_en_reg[gi]   <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Bundle age comparison between lane heads (modular sequence tags)
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_age
            for (gj = 0; gj < LANES; gj++) begin : g_pair
                logic [SEQ_W-1:0] seq_diff;
                // seq_j - seq_i wraps negative (MSB set) when j was issued first
                assign seq_diff       = head_seq[gj] - head_seq[gi];
                assign older[gi][gj]  = seq_diff[SEQ_W-1];
            end
        end
    endgenerate

    // Head selection: hold back a head while an older write to the same register is queued
    always_comb begin
        blocked  = '0;
        waw_seen = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if ((i != j) && nonempty[i] && nonempty[j] &&
                    (head_rd[i] != 5'd0) && (head_rd[i] == head_rd[j])) begin
                    if (older[i][j] || ((head_seq[i] == head_seq[j]) && (j < i))) begin
                        blocked[i] = 1'b1;
                    end
                    if (head_seq[i] == head_seq[j]) begin
                        waw_seen = 1'b1;
                    end
                end
            end
        end
    end

    assign pop = nonempty & ~blocked;

    // Sticky flag for illegal bundles writing one register twice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (waw_seen) begin
            err_reg <= 1'b1;
        end
    end

    assign bus.err_waw = err_reg;

    // Pending-write scoreboard: queued entries plus writes in the output stage
    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (entry_valid[i][k]) begin
                    busy_vec[mem_rd[i][k]] = 1'b1;
                end
            end
            if (wb_en_reg[i]) begin
                busy_vec[wb_rd_reg[i]] = 1'b1;
            end
        end
        busy_vec[0] = 1'b0;
    end

    assign bus.busy = busy_vec;

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: a queue-based reference model checked on
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_writeback_unit;
    localparam int DEPTH = 2;
    localparam int SEQ_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    writeback_unit_if #(.SEQ_W(SEQ_W)) bus ();

    writeback_unit #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [3:0]  seq;
    } ent_t;

    typedef struct {
        int          cyc;
        int          lane;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    // Reference model state
    ent_t        mq [4][$];
    logic [3:0]  m_en = '0;
    logic [4:0]  m_rd [4] = '{default: '0};
    logic [31:0] m_data [4] = '{default: '0};
    logic        m_err = 1'b0;
    bit   [3:0]  m_acc;
    bit   [3:0]  m_go;

    // Observed register-file writes
    wr_t         wlog [$];
    logic [31:0] rf_dut [32];

    logic        rdy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // a was issued before b: b lies 1..7 steps ahead of a on the 16-entry tag circle
    function automatic bit precedes(logic [3:0] a, logic [3:0] b);
        int fwd;
        fwd = (int'(b) - int'(a) + 16) % 16;
        return (fwd >= 1) && (fwd <= 7);
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            foreach (mq[i][k]) begin
                if (mq[i][k].rd != 5'd0) b[mq[i][k].rd] = 1'b1;
            end
            if (m_en[i]) b[m_rd[i]] = 1'b1;
        end
        return b;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: advances one step per clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mq[i].delete();
                m_rd[i]   = '0;
                m_data[i] = '0;
            end
            m_en  = '0;
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_acc[i] = bus.res_valid[i] && (mq[i].size() < DEPTH);
                m_go[i]  = (mq[i].size() > 0);
            end
            for (int i = 0; i < 4; i++) begin
                if (m_go[i] && mq[i][0].rd != 5'd0) begin
                    for (int j = 0; j < 4; j++) begin
                        if (j != i && mq[j].size() > 0 && mq[j][0].rd == mq[i][0].rd) begin
                            if (precedes(mq[j][0].seq, mq[i][0].seq) ||
                                (mq[j][0].seq == mq[i][0].seq && j < i)) begin
                                m_go[i] = 1'b0;
                            end
                            if (mq[j][0].seq == mq[i][0].seq) m_err = 1'b1;
                        end
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (m_go[i]) begin
                    m_en[i]   = (mq[i][0].rd != 5'd0);
                    m_rd[i]   = mq[i][0].rd;
                    m_data[i] = mq[i][0].data;
                    void'(mq[i].pop_front());
                end else begin
                    m_en[i] = 1'b0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (m_acc[i]) mq[i].push_back('{bus.res_rd[i], bus.res_data[i], bus.res_seq[i]});
            end
        end
    end

    // Per-cycle compare of every output against the model, and write logging
    always @(negedge clk) begin
        logic [3:0] exp_ready;
        logic       dup;
        for (int i = 0; i < 4; i++) exp_ready[i] = rst_n && (mq[i].size() < DEPTH);
        chk("wb_wr_en", {60'd0, bus.wb_wr_en}, {60'd0, m_en});
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wb_rd[%0d]", i), {59'd0, bus.wb_rd[i]}, {59'd0, m_rd[i]});
            chk($sformatf("wb_wr_data[%0d]", i), {32'd0, bus.wb_wr_data[i]}, {32'd0, m_data[i]});
        end
        chk("busy", {32'd0, bus.busy}, {32'd0, model_busy()});
        chk("err_waw", {63'd0, bus.err_waw}, {63'd0, m_err});
        chk("res_ready", {60'd0, bus.res_ready}, {60'd0, exp_ready});
        dup = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (bus.wb_wr_en[i] && bus.wb_wr_en[j] && bus.wb_rd[i] == bus.wb_rd[j]) dup = 1'b1;
            end
        end
        chk("no_dup_rd", {63'd0, dup}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (bus.wb_wr_en[i]) begin
                wlog.push_back('{cyc, i, bus.wb_rd[i], bus.wb_wr_data[i]});
                rf_dut[bus.wb_rd[i]] = bus.wb_wr_data[i];
            end
        end
    end

    task automatic set_lane(input int l, input logic [4:0] rd, input logic [31:0] d, input logic [3:0] s);
        bus.res_rd[l]   = rd;
        bus.res_data[l] = d;
        bus.res_seq[l]  = s;
    endtask

    // Present valid on the given lanes for exactly one clock edge
    task automatic fire(input logic [3:0] v);
        bus.res_valid = v;
        @(negedge clk);
        bus.res_valid = 4'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.res_valid = '0;
        bus.res_rd    = '0;
        bus.res_data  = '0;
        bus.res_seq   = '0;
        for (int r = 0; r < 32; r++) rf_dut[r] = '0;

        // Reset state
        idle(3);
        chk("rst_wr_en", {60'd0, bus.wb_wr_en}, 64'd0);
        chk("rst_busy", {32'd0, bus.busy}, 64'd0);
        chk("rst_err", {63'd0, bus.err_waw}, 64'd0);
        chk("rst_ready", {60'd0, bus.res_ready}, 64'd0);
        rst_n = 1'b1;
        idle(1);
        chk("ready_after_rst", {60'd0, bus.res_ready}, 64'hF);

        // 1: single LSU write, two-edge latency, busy window
        set_lane(0, 5'd5, 32'hDEADBEEF, 4'd0);
        fire(4'b0001);
        chk("t1_busy5_queued", {63'd0, bus.busy[5]}, 64'd1);
        chk("t1_en_not_yet", {63'd0, bus.wb_wr_en[0]}, 64'd0);
        idle(1);
        chk("t1_en", {63'd0, bus.wb_wr_en[0]}, 64'd1);
        chk("t1_rd", {59'd0, bus.wb_rd[0]}, 64'd5);
        chk("t1_data", {32'd0, bus.wb_wr_data[0]}, 64'hDEADBEEF);
        chk("t1_busy5_out", {63'd0, bus.busy[5]}, 64'd1);
        idle(1);
        chk("t1_busy5_clear", {63'd0, bus.busy[5]}, 64'd0);
        chk("t1_en_drop", {63'd0, bus.wb_wr_en[0]}, 64'd0);

        // 2: four independent registers in one bundle write together
        for (int i = 0; i < 4; i++) set_lane(i, 5'(i + 1), 32'h100 + 32'(i), 4'd1);
        fire(4'b1111);
        idle(1);
        chk("t2_all_en", {60'd0, bus.wb_wr_en}, 64'hF);
        idle(2);

        // 3: same register, consecutive bundles -> older first
        wlog.delete();
        set_lane(0, 5'd7, 32'hAAAA0001, 4'd3);
        set_lane(1, 5'd7, 32'hBBBB0002, 4'd4);
        fire(4'b0011);
        idle(4);
        chk("t3_count", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("t3_first_lane", 64'(wlog[0].lane), 64'd0);
            chk("t3_second_lane", 64'(wlog[1].lane), 64'd1);
            chk("t3_next_cycle", 64'(wlog[1].cyc - wlog[0].cyc), 64'd1);
        end
        chk("t3_rf_r7", {32'd0, rf_dut[7]}, 64'hBBBB0002);

        // 4: tag wrap, seq 15 precedes seq 0
        wlog.delete();
        set_lane(1, 5'd9, 32'h0000_0015, 4'd15);
        set_lane(2, 5'd9, 32'h0000_0020, 4'd0);
        fire(4'b0110);
        idle(4);
        chk("t4_count", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("t4_first_lane", 64'(wlog[0].lane), 64'd1);
            chk("t4_second_data", {32'd0, wlog[1].data}, 64'h20);
            chk("t4_next_cycle", 64'(wlog[1].cyc - wlog[0].cyc), 64'd1);
        end

        // 5: rd 0 drains without writing
        wlog.delete();
        set_lane(2, 5'd0, 32'hFFFFFFFF, 4'd5);
        fire(4'b0100);
        chk("t5_busy", {32'd0, bus.busy}, 64'd0);
        idle(1);
        chk("t5_en", {63'd0, bus.wb_wr_en[2]}, 64'd0);
        chk("t5_popped_rd", {59'd0, bus.wb_rd[2]}, 64'd0);
        chk("t5_popped_data", {32'd0, bus.wb_wr_data[2]}, 64'hFFFFFFFF);
        idle(2);
        chk("t5_no_writes", 64'(wlog.size()), 64'd0);
        chk("t5_err", {63'd0, bus.err_waw}, 64'd0);

        // 6a: backpressure on a full lane, writes ordered by bundle
        wlog.delete();
        set_lane(0, 5'd8, 32'd1, 4'd1);
        set_lane(2, 5'd8, 32'd3, 4'd3);
        fire(4'b0101);
        set_lane(0, 5'd8, 32'd2, 4'd2);
        set_lane(2, 5'd8, 32'd4, 4'd4);
        fire(4'b0101);
        chk("t6_full_ready2", {63'd0, bus.res_ready[2]}, 64'd0);
        set_lane(2, 5'd8, 32'd5, 4'd5);
        bus.res_valid = 4'b0100;
        rdy = 1'b0;
        for (int t = 0; t < 20; t++) begin
            rdy = bus.res_ready[2];
            @(negedge clk);
            if (rdy) break;
        end
        bus.res_valid = 4'b0;
        chk("t6_seq5_accepted", {63'd0, rdy}, 64'd1);
        idle(6);
        chk("t6_count", 64'(wlog.size()), 64'd5);
        if (wlog.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("t6_order%0d", k), {32'd0, wlog[k].data}, 64'(k + 1));
            end
        end

        // 6b: illegal equal-seq bundle, lower lane first, sticky error
        wlog.delete();
        set_lane(0, 5'd8, 32'd6, 4'd6);
        set_lane(3, 5'd8, 32'd7, 4'd6);
        fire(4'b1001);
        idle(4);
        chk("t6_err_waw", {63'd0, bus.err_waw}, 64'd1);
        chk("t6_eq_count", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("t6_eq_first", 64'(wlog[0].lane), 64'd0);
            chk("t6_eq_second", 64'(wlog[1].lane), 64'd3);
            chk("t6_eq_next_cycle", 64'(wlog[1].cyc - wlog[0].cyc), 64'd1);
        end

        // 6c: asynchronous reset mid-run
        set_lane(1, 5'd10, 32'hA, 4'd7);
        set_lane(2, 5'd11, 32'hB, 4'd7);
        fire(4'b0110);
        set_lane(1, 5'd12, 32'hC, 4'd8);
        fire(4'b0010);
        chk("t6_pre_rst_en", {63'd0, bus.wb_wr_en[1]}, 64'd1);
        chk("t6_pre_rst_busy12", {63'd0, bus.busy[12]}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_en", {60'd0, bus.wb_wr_en}, 64'd0);
        chk("t6_rst_busy", {32'd0, bus.busy}, 64'd0);
        chk("t6_rst_ready", {60'd0, bus.res_ready}, 64'd0);
        chk("t6_rst_err", {63'd0, bus.err_waw}, 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("t6_post_rst_ready", {60'd0, bus.res_ready}, 64'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
